ex_mem_reg: RTL

- EX/MEM pipeline register of the 5-stage RISC-V core. It sits between the execute stage and the MEM stage.
- Latches EX results and control every cycle. Supports stall (hold) and flush (bubble), and tracks a per-slot valid bit.
- Performs WB-to-MEM store-data forwarding, so a load followed immediately by a dependent store gets correct write data.
- Outputs drive the MEM stage and the data memory directly.

---
 rtl/riscv_pipe_pkg.sv | 17 +
 rtl/store_fwd_unit.sv | 24 ++
 rtl/ex_mem_reg.sv | 103 ++++++++++
 3 files changed

// File: rtl/riscv_pipe_pkg.sv
// riscv_pipe_pkg: shared pipeline widths and the MEM/WB control bundle
//   XLEN       datapath width
//   REG_AW     register-file address width
//   mem_ctrl_t packed control bits carried from ID/EX through MEM/WB
//   BUBBLE     all-zero control bundle used for flushed slots
package riscv_pipe_pkg;
    localparam int XLEN = 32;
    localparam int REG_AW = 5;
    typedef struct packed {
        logic reg_write;
        logic mem_to_reg;
        logic mem_read;
        logic mem_write;
        logic branch;
    } mem_ctrl_t;
    localparam mem_ctrl_t BUBBLE = '0;
endpackage

// File: rtl/store_fwd_unit.sv
// store_fwd_unit: forwards the WB result onto the MEM-stage store data
//   valid_i, mem_write_i  MEM slot holds a real store
//   rs2_i                 store-data source register of the MEM slot
//   rd_wb_i, reg_write_wb_i, wb_data_i  WB-stage write port
//   store_data_i          rs2 data latched in EX/MEM
//   data_o                store data after forwarding
module store_fwd_unit #(
    parameter int XLEN = 32,
    parameter int REG_AW = 5
) (
    input  logic              valid_i,
    input  logic              mem_write_i,
    input  logic [REG_AW-1:0] rs2_i,
    input  logic [REG_AW-1:0] rd_wb_i,
    input  logic              reg_write_wb_i,
    input  logic [XLEN-1:0]   wb_data_i,
    input  logic [XLEN-1:0]   store_data_i,
    output logic [XLEN-1:0]   data_o
);
    logic fwd;
    // x0 writes are architecturally discarded, so they must never forward
    assign fwd = valid_i && mem_write_i && reg_write_wb_i && (rd_wb_i != '0) && (rd_wb_i == rs2_i);
    assign data_o = fwd ? wb_data_i : store_data_i;
endmodule

// File: rtl/ex_mem_reg.sv
// ex_mem_reg: EX/MEM pipeline register with stall, flush and store-data forwarding
//   clk, reset (sync, active-low), stall (hold), flush (bubble)
//   *_EX inputs   results and control from execute
//   RD_WB, RegWrite_WB, WB_DATA  write-back port used for store forwarding
//   *_MEM outputs registered slot contents driving MEM and data memory
//   REG_DATA2_MEM_FINAL  store data after WB forwarding
//   valid_MEM     slot holds a real instruction
module ex_mem_reg #(
    parameter int XLEN = riscv_pipe_pkg::XLEN,
    parameter int REG_AW = riscv_pipe_pkg::REG_AW
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              flush,
    input  logic [REG_AW-1:0] RD_EX,
    input  logic [REG_AW-1:0] RS2_EX,
    input  logic              RegWrite_EX,
    input  logic              MemtoReg_EX,
    input  logic              MemRead_EX,
    input  logic              MemWrite_EX,
    input  logic              Branch_EX,
    input  logic              Zero_EX,
    input  logic [XLEN-1:0]   ALU_OUT_EX,
    input  logic [XLEN-1:0]   PC_Branch_EX,
    input  logic [XLEN-1:0]   REG_DATA2_EX,
    input  logic [REG_AW-1:0] RD_WB,
    input  logic              RegWrite_WB,
    input  logic [XLEN-1:0]   WB_DATA,
    output logic [REG_AW-1:0] RD_MEM,
    output logic [REG_AW-1:0] RS2_MEM,
    output logic              RegWrite_MEM,
    output logic              MemtoReg_MEM,
    output logic              MemRead_MEM,
    output logic              MemWrite_MEM,
    output logic              Branch_MEM,
    output logic              Zero_MEM,
    output logic [XLEN-1:0]   ALU_OUT_MEM,
    output logic [XLEN-1:0]   PC_Branch_MEM,
    output logic [XLEN-1:0]   REG_DATA2_MEM_FINAL,
    output logic              valid_MEM
);
    import riscv_pipe_pkg::*;
    mem_ctrl_t         ctrl_q, ctrl_d, ctrl_ex;
    logic [REG_AW-1:0] rd_q, rd_d, rs2_q, rs2_d;
    logic              zero_q, zero_d, valid_q, valid_d;
    logic [XLEN-1:0]   alu_q, alu_d, pc_q, pc_d, data2_q, data2_d;
    assign ctrl_ex = {RegWrite_EX, MemtoReg_EX, MemRead_EX, MemWrite_EX, Branch_EX};
    // Under stall the rs2 data register re-captures the forwarded value so a
    // WB producer that retires during the stall is not lost.
    always_comb begin
        ctrl_d  = flush ? BUBBLE : stall ? ctrl_q : ctrl_ex;
        rd_d    = flush ? '0 : stall ? rd_q : RD_EX;
        rs2_d   = flush ? '0 : stall ? rs2_q : RS2_EX;
        zero_d  = flush ? 1'b0 : stall ? zero_q : Zero_EX;
        alu_d   = flush ? '0 : stall ? alu_q : ALU_OUT_EX;
        pc_d    = flush ? '0 : stall ? pc_q : PC_Branch_EX;
        data2_d = flush ? '0 : stall ? REG_DATA2_MEM_FINAL : REG_DATA2_EX;
        valid_d = flush ? 1'b0 : stall ? valid_q : 1'b1;
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            ctrl_q  <= BUBBLE;
            rd_q    <= '0;
            rs2_q   <= '0;
            zero_q  <= 1'b0;
            alu_q   <= '0;
            pc_q    <= '0;
            data2_q <= '0;
            valid_q <= 1'b0;
        end else begin
            ctrl_q  <= ctrl_d;
            rd_q    <= rd_d;
            rs2_q   <= rs2_d;
            zero_q  <= zero_d;
            alu_q   <= alu_d;
            pc_q    <= pc_d;
            data2_q <= data2_d;
            valid_q <= valid_d;
        end
    end
    store_fwd_unit #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd (
        .valid_i        (valid_q),
        .mem_write_i    (ctrl_q.mem_write),
        .rs2_i          (rs2_q),
        .rd_wb_i        (RD_WB),
        .reg_write_wb_i (RegWrite_WB),
        .wb_data_i      (WB_DATA),
        .store_data_i   (data2_q),
        .data_o         (REG_DATA2_MEM_FINAL)
    );
    assign RD_MEM        = rd_q;
    assign RS2_MEM       = rs2_q;
    assign RegWrite_MEM  = ctrl_q.reg_write;
    assign MemtoReg_MEM  = ctrl_q.mem_to_reg;
    assign MemRead_MEM   = ctrl_q.mem_read;
    assign MemWrite_MEM  = ctrl_q.mem_write;
    assign Branch_MEM    = ctrl_q.branch;
    assign Zero_MEM      = zero_q;
    assign ALU_OUT_MEM   = alu_q;
    assign PC_Branch_MEM = pc_q;
    assign valid_MEM     = valid_q;
endmodule
